// File: rtl/pe_pkg.sv
// Shared PE definitions: default element/config widths and the ifmap
// transmitter state encoding.
package pe_pkg;

    localparam int DATA_SIZE_DEF    = 8;
    localparam int IFMAP_NUM_DEF    = 1;
    localparam int FIFO_DEPTH_DEF   = 4;
    localparam int CONFIG_Q_BIT_DEF = 2;
    localparam int CONFIG_W_BIT_DEF = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/pe_sync_fifo.sv
// Small synchronous FIFO. The head word is read straight from the storage
// array, so a word pushed into an empty FIFO shows on dout one cycle later.
module pe_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; reset clears contents so dout reads 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)
                count <= count + (AW+1)'(1);
            else if (!push_ok && pop_ok)
                count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/pe_ifmap_tx.sv
// Ifmap transmitter: stages GLB words in a FIFO and streams exactly
// W*(q+1) of them into one PE per start, in arrival order.
module pe_ifmap_tx
    import pe_pkg::*;
#(
    parameter int DATA_SIZE    = DATA_SIZE_DEF,
    parameter int IFMAP_NUM    = IFMAP_NUM_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int CONFIG_Q_BIT = CONFIG_Q_BIT_DEF,
    parameter int CONFIG_W_BIT = CONFIG_W_BIT_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           set_info,
    input  logic [CONFIG_Q_BIT-1:0]        config_q,
    input  logic [CONFIG_W_BIT-1:0]        config_W,
    input  logic                           start,
    input  logic [IFMAP_NUM*DATA_SIZE-1:0] in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [IFMAP_NUM*DATA_SIZE-1:0] ifmap,
    output logic                           ifmap_enable,
    input  logic                           ifmap_ready,
    output logic                           busy,
    output logic                           done
);

    localparam int WORD_W = IFMAP_NUM * DATA_SIZE;
    localparam int CNT_W  = CONFIG_W_BIT + CONFIG_Q_BIT;

    tx_state_t               state;
    logic [CONFIG_Q_BIT-1:0] cfg_q;
    logic [CONFIG_W_BIT-1:0] cfg_W;
    logic [CNT_W-1:0]        total;
    logic [CNT_W-1:0]        in_cnt;
    logic [CNT_W-1:0]        out_cnt;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic [CONFIG_Q_BIT-1:0] q_sel;
    logic [CONFIG_W_BIT-1:0] w_sel;
    logic [CNT_W-1:0]        total_nxt;

    // A set_info arriving with start must already govern that transfer.
    assign q_sel     = set_info ? config_q : cfg_q;
    assign w_sel     = set_info ? config_W : cfg_W;
    assign total_nxt = CNT_W'(w_sel) * (CNT_W'(q_sel) + CNT_W'(1));

    // Handshake qualifiers depend on registered state only.
    assign in_ready     = (state == SEND) && !fifo_full && (in_cnt != total);
    assign ifmap_enable = (state == SEND) && !fifo_empty;
    assign push         = in_valid && in_ready;
    assign pop          = ifmap_enable && ifmap_ready;

    pe_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (ifmap),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Transfer FSM with config latch, word counters and registered busy/done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cfg_q   <= '0;
            cfg_W   <= '0;
            total   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (set_info) begin
                        cfg_q <= config_q;
                        cfg_W <= config_W;
                    end
                    if (start) begin
                        total   <= total_nxt;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        busy    <= 1'b1;
                        if (total_nxt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (push) in_cnt <= in_cnt + CNT_W'(1);
                    if (pop) begin
                        out_cnt <= out_cnt + CNT_W'(1);
                        if (out_cnt == total - CNT_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
